// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch PC, issues req/ack reads to instruction
// memory, applies execute redirects and hands one instruction at a time to
// decode over a valid/ready port. All outputs are registered.
//
// Optional feature macro: FETCH_MISALIGN_CHK_EN
//   defined   : a redirect to a non-word-aligned target pulses misalign_err,
//               drops the held instruction and parks in HALT until reset.
//   undefined : redirect_pc[1:0] is forced to 2'b00, no HALT, no misalign_err.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | first cycle after reset; launches the first fetch at pc
// FETCH | imem_req high, imem_addr held until imem_ack
// HOLD  | instruction presented to decode, waiting for out_ready
// DRAIN | redirected while a request was in flight; wait for and drop the ack
// HALT  | misaligned redirect seen (macro only); finish outstanding req, stop
module fetch_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic            misalign_err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_HOLD  = 3'd2,
        S_DRAIN = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            imem_req_q, imem_req_d;
    logic [XLEN-1:0] imem_addr_q, imem_addr_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_inst_q, out_inst_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [XLEN-1:0] redir_pc;
    logic [XLEN-1:0] drain_next;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_q, misalign_d;
    logic redir_misaligned;
    assign redir_pc         = redirect_pc;
    assign redir_misaligned = |redirect_pc[1:0];
`else
    // Without the checker the low address bits are simply ignored.
    assign redir_pc = redirect_pc & ~XLEN'(3);
`endif

    // Latest target wins while draining; a same-cycle redirect overrides pc.
    assign drain_next = redirect_valid ? redir_pc : pc_q;

    // Next-state and next-output computation; redirect takes priority everywhere.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;
`ifdef FETCH_MISALIGN_CHK_EN
        misalign_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                state_d     = S_FETCH;
                imem_req_d  = 1'b1;
                out_valid_d = 1'b0;
                if (redirect_valid) begin
                    pc_d        = redir_pc;
                    imem_addr_d = redir_pc;
                end else begin
                    imem_addr_d = pc_q;
                end
            end
            S_FETCH: begin
                if (redirect_valid) begin
                    pc_d = redir_pc;
                    if (imem_ack) begin
                        imem_addr_d = redir_pc;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (imem_ack) begin
                    out_inst_d  = imem_rdata;
                    out_pc_d    = imem_addr_q;
                    out_valid_d = 1'b1;
                    pc_d        = pc_q + XLEN'(PC_STEP);
                    imem_req_d  = 1'b0;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d        = redir_pc;
                    imem_addr_d = redir_pc;
                    out_valid_d = 1'b0;
                    imem_req_d  = 1'b1;
                    state_d     = S_FETCH;
                end else if (out_ready && out_valid_q) begin
                    out_valid_d = 1'b0;
                    imem_addr_d = pc_q;
                    imem_req_d  = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            S_DRAIN: begin
                pc_d = drain_next;
                if (imem_ack) begin
                    imem_addr_d = drain_next;
                    state_d     = S_FETCH;
                end
            end
`ifdef FETCH_MISALIGN_CHK_EN
            S_HALT: begin
                out_valid_d = 1'b0;
                imem_req_d  = imem_req_q & ~imem_ack;
            end
`endif
            default: begin
                state_d    = S_IDLE;
                imem_req_d = 1'b0;
            end
        endcase
`ifdef FETCH_MISALIGN_CHK_EN
        // A misaligned target freezes fetch; an in-flight request is let finish.
        if (redirect_valid && redir_misaligned && state_q != S_HALT) begin
            state_d     = S_HALT;
            misalign_d  = 1'b1;
            out_valid_d = 1'b0;
            imem_req_d  = imem_req_q & ~imem_ack;
            pc_d        = pc_q;
            imem_addr_d = imem_addr_q;
            out_inst_d  = out_inst_q;
            out_pc_d    = out_pc_q;
        end
`endif
    end

    // State and output registers; reset abandons any outstanding request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_pc_q    <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_pc_q    <= out_pc_d;
`ifdef FETCH_MISALIGN_CHK_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign out_valid = out_valid_q;
    assign out_inst  = out_inst_q;
    assign out_pc    = out_pc_q;
`ifdef FETCH_MISALIGN_CHK_EN
    assign misalign_err = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a latency-programmable memory model, directed
// stimulus pushing hand-computed expectations into queues, and a monitor
// that pops and compares on every memory ack and every decode handshake.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        misalign_err;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } out_t;

    out_t        exp_out[$];
    logic [31:0] exp_addr[$];
    int          checks = 0;
    int          errors = 0;
    int          lat = 0;
    int          inject_cnt = 0;

    fetch_sequencer #(.XLEN(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .misalign_err   (misalign_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk(name, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic accept(input string name);
        wait_valid(name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic push_out(input logic [31:0] pc, input logic [31:0] inst);
        out_t o;
        o.pc   = pc;
        o.inst = inst;
        exp_out.push_back(o);
    endtask

    // Memory: acks after `lat` idle cycles, data word = {C0DE, addr[15:0]}.
    initial begin
        int cnt = 0;
        int seen = 0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                imem_ack = 1'b0;
                cnt      = 0;
            end else if (imem_ack) begin
                imem_ack = 1'b0;
                cnt      = 0;
            end else if (inject_cnt != seen) begin
                seen       = inject_cnt;
                imem_ack   = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
            end else if (imem_req) begin
                if (cnt >= lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = {16'hC0DE, imem_addr[15:0]};
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: compares every accepted memory read and every decode handshake.
    initial begin
        logic        prev_req = 1'b0;
        logic        prev_ack = 1'b0;
        logic [31:0] prev_addr = 32'h0;
        logic [31:0] a;
        out_t        o;
        forever begin
            @(negedge clk);
            #3;
            if (!reset) begin
                if (prev_req && !prev_ack) begin
                    chk("req_held", {31'd0, imem_req}, 32'd1);
                    chk("addr_stable", imem_addr, prev_addr);
                end
                if (imem_req && imem_ack) begin
                    if (exp_addr.size() == 0) begin
                        chk("unexpected_fetch", imem_addr, 32'hxxxx_xxxx);
                    end else begin
                        a = exp_addr.pop_front();
                        chk("imem_addr", imem_addr, a);
                    end
                end
                if (out_valid && out_ready) begin
                    if (exp_out.size() == 0) begin
                        chk("unexpected_out", out_pc, 32'hxxxx_xxxx);
                    end else begin
                        o = exp_out.pop_front();
                        chk("out_pc", out_pc, o.pc);
                        chk("out_inst", out_inst, o.inst);
                    end
                end
            end
            prev_req  = reset ? 1'b0 : imem_req;
            prev_ack  = imem_ack;
            prev_addr = imem_addr;
        end
    end

    initial begin
        int n;
        reset          = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        tick();
        tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_inst", out_inst, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
`endif

        // 1: sequential fetch with 1-cycle ack and decode always ready
        foreach (exp_addr[i]) exp_addr.delete(i);
        exp_addr.push_back(32'h0);
        exp_addr.push_back(32'h4);
        exp_addr.push_back(32'h8);
        exp_addr.push_back(32'hC);
        exp_addr.push_back(32'h10);
        push_out(32'h0, 32'hC0DE_0000);
        push_out(32'h4, 32'hC0DE_0004);
        push_out(32'h8, 32'hC0DE_0008);
        push_out(32'hC, 32'hC0DE_000C);
        out_ready = 1'b1;
        reset     = 1'b0;
        tick();
        chk("idle_to_fetch", {31'd0, imem_req}, 32'd1);
        n = 0;
        while (exp_out.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk("seq_drained", exp_out.size(), 32'd0);
        out_ready = 1'b0;

        // 2: decode stalls, held instruction stable, stray ack ignored
        wait_valid("hold_valid");
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid_st", {31'd0, out_valid}, 32'd1);
            chk("hold_pc_st", out_pc, 32'h10);
            chk("hold_inst_st", out_inst, 32'hC0DE_0010);
            chk("hold_no_req", {31'd0, imem_req}, 32'd0);
            if (i == 1) inject_cnt++;
            tick();
        end
        push_out(32'h10, 32'hC0DE_0010);
        exp_addr.push_back(32'h14);
        accept("accept_10");

        // 3: redirect during HOLD drops 0x14; redirect with ack drops 0x40 data
        wait_valid("hold_14");
        exp_addr.push_back(32'h40);
        redirect(32'h40);
        chk("redir_hold_drop", {31'd0, out_valid}, 32'd0);
        n = 0;
        while (!imem_ack && n < 20) begin
            tick();
            n++;
        end
        chk("ack_40_seen", {31'd0, imem_ack}, 32'd1);
        exp_addr.push_back(32'h200);
        push_out(32'h200, 32'hC0DE_0200);
        redirect(32'h200);

        // 4: slow memory, two redirects while the 0x204 read is in flight
        exp_addr.push_back(32'h204);
        exp_addr.push_back(32'h80);
        push_out(32'h80, 32'hC0DE_0080);
        lat = 3;
        accept("accept_200");
        redirect(32'h70);
        redirect(32'h80);
        chk("drain_addr_hold", imem_addr, 32'h204);
        chk("drain_no_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_req", {31'd0, imem_req}, 32'd1);
        lat = 0;
        exp_addr.push_back(32'h84);
        accept("accept_80");

        // 5: wrap of the PC past the top of the address space
        wait_valid("hold_84");
        exp_addr.push_back(32'hFFFF_FFFC);
        push_out(32'hFFFF_FFFC, 32'hC0DE_FFFC);
        exp_addr.push_back(32'h0);
        redirect(32'hFFFF_FFFC);
        chk("wrap_drop", {31'd0, out_valid}, 32'd0);
        accept("accept_fffc");

        // 6: misaligned redirect, then reset in the middle of a fetch
        wait_valid("hold_0");
`ifdef FETCH_MISALIGN_CHK_EN
        redirect(32'h42);
        chk("misalign_pulse", {31'd0, misalign_err}, 32'd1);
        chk("misalign_drop", {31'd0, out_valid}, 32'd0);
        chk("misalign_req", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("misalign_once", {31'd0, misalign_err}, 32'd0);
            chk("halt_no_req", {31'd0, imem_req}, 32'd0);
        end
        lat   = 5;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
`else
        exp_addr.push_back(32'h40);
        push_out(32'h40, 32'hC0DE_0040);
        redirect(32'h42);
        chk("align_drop", {31'd0, out_valid}, 32'd0);
        lat = 5;
        accept("accept_40");
        tick();
`endif
        chk("pre_reset_req", {31'd0, imem_req}, 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_req", {31'd0, imem_req}, 32'd0);
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_addr", imem_addr, 32'h0);
        tick();
        lat = 0;
        exp_addr.push_back(32'h0);
        push_out(32'h0, 32'hC0DE_0000);
        exp_addr.push_back(32'h4);
        reset = 1'b0;
        accept("accept_restart");
        n = 0;
        while ((exp_addr.size() != 0 || exp_out.size() != 0) && n < 20) begin
            tick();
            n++;
        end
        chk("final_addr_q", exp_addr.size(), 32'd0);
        chk("final_out_q", exp_out.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
